// File: rtl/alu_control_unit_if.sv
// Instruction, ALU and debug signals of the ALU issue/writeback controller.
// The zero_flag signal exists only when ALU_CTRL_ZERO_FLAG_EN is defined.
interface alu_control_unit_if #(
    parameter int DATA_W     = 18,
    parameter int REG_ADDR_W = 4
);
    logic                  instr_valid;
    logic [DATA_W-1:0]     instr;
    logic                  instr_ready;
    logic                  busy;
    logic [DATA_W-1:0]     alu_operand1;
    logic [DATA_W-1:0]     alu_operand2;
    logic [1:0]            alu_select;
    logic                  alu_enable;
    logic [DATA_W-1:0]     alu_result;
    logic                  done;
    logic                  illegal_op;
    logic [REG_ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0]     dbg_data;
`ifdef ALU_CTRL_ZERO_FLAG_EN
    logic                  zero_flag;
`endif

    // Instruction source / ALU / debug side
    modport master (
        output instr_valid, instr, alu_result, dbg_addr,
        input  instr_ready, busy, alu_operand1, alu_operand2, alu_select,
               alu_enable, done, illegal_op, dbg_data
`ifdef ALU_CTRL_ZERO_FLAG_EN
        , input zero_flag
`endif
    );

    // Controller side
    modport slave (
        input  instr_valid, instr, alu_result, dbg_addr,
        output instr_ready, busy, alu_operand1, alu_operand2, alu_select,
               alu_enable, done, illegal_op, dbg_data
`ifdef ALU_CTRL_ZERO_FLAG_EN
        , output zero_flag
`endif
    );
endinterface

// File: rtl/alu_control_unit.sv
// Issue/writeback controller for an 18-bit registered ALU with a 16x18 register file.
// Optional zero_flag output enabled by defining ALU_CTRL_ZERO_FLAG_EN.
module alu_control_unit #(
    parameter int DATA_W     = 18,
    parameter int REG_ADDR_W = 4
) (
    input  logic clk,
    input  logic reset,
    alu_control_unit_if.slave bus
);
    localparam int NUM_REGS = 1 << REG_ADDR_W;

    typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

    state_t                 state_reg, state_next;
    logic [REG_ADDR_W-1:0]  dest_reg;
    logic [DATA_W-1:0]      op1_reg, op2_reg;
    logic [1:0]             sel_reg;
    logic                   illegal_reg;
    logic [DATA_W-1:0]      rf_reg [NUM_REGS];
    logic [NUM_REGS-1:0]    wr_sel;

    logic                   instr_ready_c, busy_c, alu_enable_c, done_c;

    // Fields of the offered instruction
    logic [3:0]             in_opcode;
    logic [REG_ADDR_W-1:0]  in_dest, in_src1, in_src2;
    logic [DATA_W-1:0]      in_imm;
    logic                   accept;

    assign in_opcode = bus.instr[17:14];
    assign in_dest   = bus.instr[13:10];
    assign in_src1   = bus.instr[9:6];
    assign in_src2   = bus.instr[5:2];
    assign in_imm    = {{(DATA_W-6){1'b0}}, bus.instr[5:0]};
    assign accept    = bus.instr_valid && (state_reg == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        instr_ready_c = 1'b0;
        busy_c        = 1'b1;
        alu_enable_c  = 1'b0;
        done_c        = 1'b0;
        case (state_reg)
            IDLE: begin
                instr_ready_c = 1'b1;
                busy_c        = 1'b0;
                // Illegal opcodes are consumed without leaving IDLE
                if (bus.instr_valid && !in_opcode[3]) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                alu_enable_c = 1'b1;
                state_next   = WB;
            end
            WB: begin
                done_c     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operands are captured at accept; the register file cannot change until the
    // following writeback, so these match what ISSUE would read and then hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dest_reg    <= '0;
            op1_reg     <= '0;
            op2_reg     <= '0;
            sel_reg     <= '0;
            illegal_reg <= 1'b0;
        end else if (accept) begin
            if (in_opcode[3]) begin
                illegal_reg <= 1'b1;
            end else begin
                dest_reg <= in_dest;
                op1_reg  <= rf_reg[in_src1];
                op2_reg  <= in_opcode[2] ? in_imm : rf_reg[in_src2];
                sel_reg  <= in_opcode[1:0];
            end
        end
    end

    // Register 0 never gets a write strobe, so it stays at its reset value of 0
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_sel
            if (gi == 0) begin : g_zero
                assign wr_sel[gi] = 1'b0;
            end else begin : g_reg
                assign wr_sel[gi] = (state_reg == WB) && (dest_reg == REG_ADDR_W'(gi));
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    rf_reg[i] <= bus.alu_result;
                end
            end
        end
    end

`ifdef ALU_CTRL_ZERO_FLAG_EN
    logic zero_flag_reg;

    // Reflects the raw ALU result, even when the write to r0 is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_flag_reg <= 1'b0;
        end else if (state_reg == WB) begin
            zero_flag_reg <= (bus.alu_result == '0);
        end
    end

    assign bus.zero_flag = zero_flag_reg;
`endif

    assign bus.instr_ready  = instr_ready_c;
    assign bus.busy         = busy_c;
    assign bus.alu_enable   = alu_enable_c;
    assign bus.done         = done_c;
    assign bus.alu_operand1 = op1_reg;
    assign bus.alu_operand2 = op2_reg;
    assign bus.alu_select   = sel_reg;
    assign bus.illegal_op   = illegal_reg;
    assign bus.dbg_data     = rf_reg[bus.dbg_addr];

endmodule

// File: tb/tb_alu_control_unit.sv
// Self-checking bench for alu_control_unit: directed plan plus random instructions
// against a register-file reference model; also covers zero_flag when ALU_CTRL_ZERO_FLAG_EN is defined.
module tb_alu_control_unit;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    alu_control_unit_if #(.DATA_W(18), .REG_ADDR_W(4)) bus ();

    alu_control_unit #(.DATA_W(18), .REG_ADDR_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state
    logic [17:0] ref_rf [16];
    logic [17:0] ref_op1, ref_op2;
    logic [1:0]  ref_sel;
    logic        ref_illegal;
    logic        ref_zero;

    function automatic logic [17:0] alu_math(input logic [1:0] sel,
                                             input logic [17:0] a, input logic [17:0] b);
        int unsigned s;
        case (sel)
            2'd0: begin s = (int'(a) + int'(b)) % 262144; return 18'(s); end
            2'd1: return a & b;
            2'd2: return ~(a & b);
            default: return ~(a | b);
        endcase
    endfunction

    // Registered ALU sitting behind the controller
    always @(posedge clk or posedge reset) begin
        if (reset) bus.alu_result <= '0;
        else if (bus.alu_enable)
            bus.alu_result <= alu_math(bus.alu_select, bus.alu_operand1, bus.alu_operand2);
    end

    function automatic logic [17:0] mk(input logic [3:0] op, input logic [3:0] d,
                                       input logic [3:0] s1, input logic [5:0] low);
        return {op, d, s1, low};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic dbgchk(input logic [3:0] a, input logic [17:0] exp);
        @(negedge clk);
        bus.dbg_addr = a;
        #1 chk($sformatf("dbg_r%0d", a), 32'(bus.dbg_data), 32'(exp));
    endtask

    task automatic ref_clear();
        for (int i = 0; i < 16; i++) ref_rf[i] = '0;
        ref_op1 = '0; ref_op2 = '0; ref_sel = '0; ref_illegal = 1'b0; ref_zero = 1'b0;
    endtask

    // Entered and left just after a falling edge with the controller in IDLE
    task automatic do_instr(input logic [17:0] ins, input bit hold, input logic [17:0] held);
        logic [3:0]  op, d, s1, s2;
        logic [17:0] a, b, res;
        op = ins[17:14]; d = ins[13:10]; s1 = ins[9:6]; s2 = ins[5:2];
        bus.instr = ins;
        bus.instr_valid = 1'b1;
        #1 chk("ready_idle", 32'(bus.instr_ready), 32'd1);
        @(posedge clk);
        #1;
        if (hold) bus.instr = held;
        else      bus.instr_valid = 1'b0;
        if (op[3]) begin
            ref_illegal = 1'b1;
            @(negedge clk);
            chk("illegal_set", 32'(bus.illegal_op), 32'd1);
            chk("illegal_no_en", 32'(bus.alu_enable), 32'd0);
            chk("illegal_no_done", 32'(bus.done), 32'd0);
            chk("illegal_idle", 32'(bus.busy), 32'd0);
            chk("illegal_op1_hold", 32'(bus.alu_operand1), 32'(ref_op1));
        end else begin
            a = ref_rf[s1];
            b = op[2] ? {12'd0, ins[5:0]} : ref_rf[s2];
            ref_op1 = a; ref_op2 = b; ref_sel = op[1:0];
            @(negedge clk);
            chk("issue_en", 32'(bus.alu_enable), 32'd1);
            chk("issue_op1", 32'(bus.alu_operand1), 32'(ref_op1));
            chk("issue_op2", 32'(bus.alu_operand2), 32'(ref_op2));
            chk("issue_sel", 32'(bus.alu_select), 32'(ref_sel));
            chk("issue_busy", 32'(bus.busy), 32'd1);
            chk("issue_ready", 32'(bus.instr_ready), 32'd0);
            chk("issue_done", 32'(bus.done), 32'd0);
            @(negedge clk);
            chk("wb_done", 32'(bus.done), 32'd1);
            chk("wb_en", 32'(bus.alu_enable), 32'd0);
            chk("wb_ready", 32'(bus.instr_ready), 32'd0);
            chk("wb_op2_hold", 32'(bus.alu_operand2), 32'(ref_op2));
            res = alu_math(op[1:0], a, b);
            if (d != 4'd0) ref_rf[d] = res;
            ref_zero = (res == 18'd0);
            @(negedge clk);
            chk("post_done", 32'(bus.done), 32'd0);
            chk("post_busy", 32'(bus.busy), 32'd0);
            bus.dbg_addr = d;
            #1 chk("wb_dbg", 32'(bus.dbg_data), 32'(ref_rf[d]));
`ifdef ALU_CTRL_ZERO_FLAG_EN
            chk("zero_flag", 32'(bus.zero_flag), 32'(ref_zero));
`endif
        end
        chk("illegal_sticky", 32'(bus.illegal_op), 32'(ref_illegal));
    endtask

    initial begin
        logic [17:0] ins;
        logic [3:0]  rop;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        bus.dbg_addr = '0;
        ref_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_en", 32'(bus.alu_enable), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_op1", 32'(bus.alu_operand1), 32'd0);
        chk("rst_op2", 32'(bus.alu_operand2), 32'd0);
        chk("rst_sel", 32'(bus.alu_select), 32'd0);
        chk("rst_illegal", 32'(bus.illegal_op), 32'd0);
`ifdef ALU_CTRL_ZERO_FLAG_EN
        chk("rst_zero", 32'(bus.zero_flag), 32'd0);
`endif
        reset = 1'b0;
        #1 chk("rst_ready", 32'(bus.instr_ready), 32'd1);

        // ADD-imm r1 = r0 + 5
        do_instr(18'b0100_0001_0000_000101, 1'b0, '0);
        dbgchk(4'd1, 18'd5);

        // r1=5, r2=3, r3=r1+r2, r4=NAND(r3,r3)
        do_instr(mk(4'b0100, 4'd1, 4'd0, 6'd5), 1'b0, '0);
        do_instr(mk(4'b0100, 4'd2, 4'd0, 6'd3), 1'b0, '0);
        do_instr(mk(4'b0000, 4'd3, 4'd1, {4'd2, 2'b00}), 1'b0, '0);
        do_instr(mk(4'b0010, 4'd4, 4'd3, {4'd3, 2'b00}), 1'b0, '0);
        dbgchk(4'd3, 18'd8);
        dbgchk(4'd4, 18'h3FFF7);

        // r1 = NOR(r0,r0) = all ones, then r2 = r1 + 1 wraps to 0
        do_instr(mk(4'b0011, 4'd1, 4'd0, 6'd0), 1'b0, '0);
        dbgchk(4'd1, 18'h3FFFF);
        do_instr(mk(4'b0100, 4'd2, 4'd1, 6'd1), 1'b0, '0);
        dbgchk(4'd2, 18'd0);
`ifdef ALU_CTRL_ZERO_FLAG_EN
        chk("wrap_zero_flag", 32'(bus.zero_flag), 32'd1);
`endif

        // Second instruction held through ISSUE/WB of the first
        do_instr(mk(4'b0100, 4'd6, 4'd0, 6'd9), 1'b1, mk(4'b0101, 4'd7, 4'd6, 6'h3F));
        do_instr(mk(4'b0101, 4'd7, 4'd6, 6'h3F), 1'b0, '0);
        dbgchk(4'd7, 18'd9);
        chk("hold_once_busy", 32'(bus.busy), 32'd0);
        chk("hold_once_en", 32'(bus.alu_enable), 32'd0);

        // Illegal opcode, then a legal one
        do_instr(mk(4'b1010, 4'd1, 4'd0, 6'd5), 1'b0, '0);
        dbgchk(4'd1, 18'h3FFFF);
        do_instr(mk(4'b0100, 4'd8, 4'd0, 6'd33), 1'b0, '0);
        dbgchk(4'd8, 18'd33);

        // Random instructions
        for (int n = 0; n < 40; n++) begin
            rop = 4'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) rop[3] = 1'b1;
            ins = mk(rop, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     6'($urandom_range(0, 63)));
            do_instr(ins, 1'b0, '0);
        end
        for (int r = 0; r < 16; r++) dbgchk(4'(r), ref_rf[r]);

        // Reset during WB of ADD-imm r5 = r0 + 7
        @(negedge clk);
        bus.instr = mk(4'b0100, 4'd5, 4'd0, 6'd7);
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_wb_done", 32'(bus.done), 32'd1);
        reset = 1'b1;
        ref_clear();
        bus.dbg_addr = 4'd5;
        #1;
        chk("wbrst_r5", 32'(bus.dbg_data), 32'd0);
        chk("wbrst_busy", 32'(bus.busy), 32'd0);
        chk("wbrst_done", 32'(bus.done), 32'd0);
        chk("wbrst_en", 32'(bus.alu_enable), 32'd0);
        chk("wbrst_op1", 32'(bus.alu_operand1), 32'd0);
        chk("wbrst_op2", 32'(bus.alu_operand2), 32'd0);
        chk("wbrst_sel", 32'(bus.alu_select), 32'd0);
        chk("wbrst_illegal", 32'(bus.illegal_op), 32'd0);
`ifdef ALU_CTRL_ZERO_FLAG_EN
        chk("wbrst_zero", 32'(bus.zero_flag), 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        dbgchk(4'd5, 18'd0);
        do_instr(mk(4'b0100, 4'd5, 4'd0, 6'd7), 1'b0, '0);
        dbgchk(4'd5, 18'd7);
        for (int r = 0; r < 16; r++) dbgchk(4'(r), ref_rf[r]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_control_unit.md
Name: alu_control_unit

Overview:
- Issue/writeback controller sitting on the initiator side of the 18-bit registered ALU. It owns the ALU's operand, select and enable inputs and consumes its result.
- Accepts one 18-bit instruction at a time over a valid/ready handshake.
- Reads operands from an internal 16x18 register file, drives one ALU operation, then writes the registered ALU result back.
- Feeds the datapath from the fetch stage.

Parameters:
- DATA_W, 18, data and instruction width; the instruction format below requires 18.
- REG_ADDR_W, 4, register index width; 16 registers; the format requires 4.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- instr_valid  input  1  instruction offered
- instr  input  18  instruction word
- instr_ready  output  1  high only in IDLE
- busy  output  1  high in any state other than IDLE
- alu_operand1  output  18  to ALU operand1
- alu_operand2  output  18  to ALU operand2
- alu_select  output  2  to ALU alu_select
- alu_enable  output  1  to ALU enable
- alu_result  input  18  from ALU result (registered inside the ALU)
- done  output  1  one-cycle pulse at writeback
- illegal_op  output  1  sticky illegal-opcode flag
- dbg_addr  input  4  debug read index
- dbg_data  output  18  combinational read of reg[dbg_addr]

Behaviour:
- Instruction format:
  - [17:14] opcode; [13:10] dest; [9:6] src1.
  - Register mode: [5:2] src2, [1:0] ignored.
  - Immediate mode: [5:0] is imm6, zero-extended to 18 bits.
- Opcode decoding:
  - opcode[3]=0 is legal. alu_select = opcode[1:0] (00 ADD, 01 AND, 10 NAND, 11 NOR). opcode[2]=1 selects immediate mode for operand2.
  - opcode[3]=1 is illegal.
- Register file:
  - reg[0] always reads 0; writes to it are dropped.
  - Reads are combinational.
- FSM states: IDLE, ISSUE, WB.
  - IDLE: instr_ready=1. On instr_valid & instr_ready at edge E0, latch instr.
    - Legal opcode: go to ISSUE.
    - Illegal opcode: set illegal_op=1, stay in IDLE, no done pulse, no ALU enable.
  - ISSUE (one cycle): alu_enable=1. alu_operand1 = reg[src1]. alu_operand2 = reg[src2] or imm6. alu_select from the latched opcode. At edge E1 the ALU registers its result; FSM goes to WB.
  - WB (one cycle): alu_enable=0, done=1. At edge E2, reg[dest] <= alu_result; FSM goes to IDLE.
- Latency and throughput: accept to register update is 2 edges after E0. Throughput is one instruction per 3 cycles.
- ALU output defaults: alu_operand1, alu_operand2 and alu_select hold the last issued values outside ISSUE. alu_enable is high only in ISSUE.
- Arithmetic: ADD wraps mod 2^18 (performed in the ALU). This block adds no carry handling.
- instr_valid while busy: ignored, not latched. The instruction must be held by the source until accepted.
- Hazards: src1/src2 equal to the previous instruction's dest read the written-back value. This is guaranteed because accept only occurs after WB completes.
- Reset (async, any state, including mid-ISSUE or mid-WB):
  - FSM goes to IDLE. All registers clear to 0. The pending writeback is discarded.
  - Outputs: instr_ready=1 after reset deasserts. busy=0, alu_enable=0, alu_operand1=0, alu_operand2=0, alu_select=0, done=0, illegal_op=0.
- illegal_op: cleared only by reset.

Optional Feature:
- Macro: ALU_CTRL_ZERO_FLAG_EN
- Defined:
  - Adds output zero_flag (1 bit, reset 0).
  - At the WB edge, zero_flag <= (alu_result == 0), including when dest = 0.
  - zero_flag holds between instructions; illegal ops do not change it.
- Undefined: no zero_flag port and no related logic.

Test Plan:
- Reset, then accept instr 0b0100_0001_0000_000101 (ADD-imm r1 = r0+5):
  - alu_enable high exactly in the cycle after accept, with operand2 = 5.
  - done pulses 2 cycles after accept.
  - dbg_addr=1 gives dbg_data=5.
- Load r1=5 and r2=3 (imm), then ADD r3=r1+r2 (register mode): r3=8. Then NAND r4=r3,r3: r4=0x3FFF7.
- Load r1=0x3FFFF via repeated ops (NOR r1=r0,r0), then ADD-imm r2=r1+1: r2=0 (wrap).
  - With ALU_CTRL_ZERO_FLAG_EN defined, zero_flag=1.
- Hold instr_valid high through ISSUE/WB with a different instr: instr_ready=0, second instr accepted only on return to IDLE, and executed once.
- Opcode 0b1010: illegal_op=1 the next cycle, no alu_enable, no done, registers unchanged; the next legal instruction still executes.
- Assert reset during WB of ADD-imm r5=r0+7: r5=0 and all outputs at reset values; the next instruction is accepted normally.
